// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types for the cache fill arbiter: FSM states, fill ownership and
// the block-offset width helper.
package cache_fill_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   localparam int WORDS_DEFAULT = 8;

   // Byte-offset bits inside one block of 16-bit words.
   function automatic int blk_off_w(input int words);
      return $clog2(words * 2);
   endfunction

endpackage

// File: rtl/cache_fill_arbiter_fill_counter.sv
// Word-index up-counter used for both the issue and the return side of a fill.
module fill_counter #(
   parameter int IDX_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [IDX_W-1:0] count,
   output logic             last
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 1'b1;
      end
   end

   assign last = &count;

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates the shared main-memory port between I-cache fills, D-cache fills
// and D-cache write-through stores; fills are issued back-to-back and returns
// are steered to the owning cache.
module cache_fill_arbiter
   import cache_fill_arbiter_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int WORDS  = WORDS_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       i_miss,
   input  logic [ADDR_W-1:0]          i_miss_addr,
   input  logic                       d_miss,
   input  logic [ADDR_W-1:0]          d_miss_addr,
   input  logic                       d_wr_req,
   input  logic [ADDR_W-1:0]          d_wr_addr,
   input  logic [DATA_W-1:0]          d_wr_data,
   input  logic                       mem_rvalid,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic                       mem_en,
   output logic                       mem_wr,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   output logic [DATA_W-1:0]          fill_data,
   output logic [$clog2(WORDS)-1:0]   fill_idx,
   output logic                       i_fill_we,
   output logic                       d_fill_we,
   output logic                       i_tag_we,
   output logic                       d_tag_we,
   output logic                       i_stall,
   output logic                       d_stall,
   output logic                       busy
);

   localparam int IDX_W = $clog2(WORDS);
   localparam int OFF_W = blk_off_w(WORDS);
   localparam logic [ADDR_W-1:0] BLK_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

   state_t            state, state_next;
   owner_t            owner, owner_next;
   logic [ADDR_W-1:0] base, base_next;

   logic              iss_clr, iss_inc, iss_last;
   logic              ret_clr, ret_inc, ret_last;
   logic [IDX_W-1:0]  iss_cnt, ret_cnt;
   logic              ret_hit;

   fill_counter #(.IDX_W(IDX_W)) u_iss_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (iss_clr),
      .inc   (iss_inc),
      .count (iss_cnt),
      .last  (iss_last)
   );

   fill_counter #(.IDX_W(IDX_W)) u_ret_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (ret_clr),
      .inc   (ret_inc),
      .count (ret_cnt),
      .last  (ret_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         owner <= OWN_NONE;
         base  <= '0;
      end else begin
         state <= state_next;
         owner <= owner_next;
         base  <= base_next;
      end
   end

   // Returns with no owner are stale (e.g. from before a reset) and ignored.
   assign ret_hit = mem_rvalid && (owner != OWN_NONE);

   always_comb begin
      state_next = state;
      owner_next = owner;
      base_next  = base;
      iss_clr    = 1'b0;
      iss_inc    = 1'b0;
      ret_clr    = 1'b0;
      ret_inc    = 1'b0;
      mem_en     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      fill_data  = '0;
      i_fill_we  = 1'b0;
      d_fill_we  = 1'b0;
      i_tag_we   = 1'b0;
      d_tag_we   = 1'b0;

      case (state)
         IDLE: begin
            if (d_miss) begin
               owner_next = OWN_D;
               base_next  = d_miss_addr & BLK_MASK;
               state_next = ISSUE;
               iss_clr    = 1'b1;
               ret_clr    = 1'b1;
            end else if (d_wr_req) begin
               mem_en    = 1'b1;
               mem_wr    = 1'b1;
               mem_addr  = d_wr_addr;
               mem_wdata = d_wr_data;
            end else if (i_miss) begin
               owner_next = OWN_I;
               base_next  = i_miss_addr & BLK_MASK;
               state_next = ISSUE;
               iss_clr    = 1'b1;
               ret_clr    = 1'b1;
            end
         end
         ISSUE: begin
            mem_en   = 1'b1;
            mem_addr = base + ADDR_W'({iss_cnt, 1'b0});
            iss_inc  = 1'b1;
            if (iss_last) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            state_next = DRAIN;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      // Return steering overrides the issue-side next state on the final word.
      if (ret_hit) begin
         fill_data = mem_rdata;
         ret_inc   = 1'b1;
         i_fill_we = (owner == OWN_I);
         d_fill_we = (owner == OWN_D);
         if (ret_last) begin
            i_tag_we   = (owner == OWN_I);
            d_tag_we   = (owner == OWN_D);
            state_next = IDLE;
            owner_next = OWN_NONE;
         end
      end
   end

   assign fill_idx = ret_cnt;
   assign busy     = (state != IDLE);
   assign i_stall  = i_miss;
   assign d_stall  = d_miss | (d_wr_req & (busy | d_miss));

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Self-checking bench for cache_fill_arbiter: a fixed-latency memory model,
// a scoreboard of expected memory requests and fill writes, and stall vectors.
module tb_cache_fill_arbiter;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int WORDS  = 8;
   localparam int IDX_W  = 3;
   localparam int LAT    = 4;

   logic              clk;
   logic              rst_n;
   logic              i_miss, d_miss, d_wr_req;
   logic [ADDR_W-1:0] i_miss_addr, d_miss_addr, d_wr_addr;
   logic [DATA_W-1:0] d_wr_data;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_en, mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, fill_data;
   logic [IDX_W-1:0]  fill_idx;
   logic              i_fill_we, d_fill_we, i_tag_we, d_tag_we;
   logic              i_stall, d_stall, busy;

   cache_fill_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_miss      (i_miss),
      .i_miss_addr (i_miss_addr),
      .d_miss      (d_miss),
      .d_miss_addr (d_miss_addr),
      .d_wr_req    (d_wr_req),
      .d_wr_addr   (d_wr_addr),
      .d_wr_data   (d_wr_data),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .mem_en      (mem_en),
      .mem_wr      (mem_wr),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .fill_data   (fill_data),
      .fill_idx    (fill_idx),
      .i_fill_we   (i_fill_we),
      .d_fill_we   (d_fill_we),
      .i_tag_we    (i_tag_we),
      .d_tag_we    (d_tag_we),
      .i_stall     (i_stall),
      .d_stall     (d_stall),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] mem_model(input logic [ADDR_W-1:0] a);
      return a ^ 16'h5A00;
   endfunction

   // Pipelined memory: a read accepted in cycle c returns in cycle c+LAT.
   logic [LAT-1:0]    pv = '0;
   logic [DATA_W-1:0] pd [LAT];
   logic              inject = 1'b0;

   always @(posedge clk) begin
      pv    <= {pv[LAT-2:0], mem_en & ~mem_wr};
      pd[0] <= mem_model(mem_addr);
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
   end

   assign mem_rvalid = pv[LAT-1] | inject;
   assign mem_rdata  = pd[LAT-1];

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } mem_exp_t;

   typedef struct packed {
      logic              i_fill;
      logic              d_fill;
      logic              i_tag;
      logic              d_tag;
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] data;
   } fill_exp_t;

   mem_exp_t  mem_q  [$];
   fill_exp_t fill_q [$];
   int vectors     = 0;
   int miscompares = 0;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic flag_fail(input string name);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: got unexpected activity, expected none", name);
   endtask

   function automatic logic [63:0] all_outs();
      return {4'b0, mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_idx,
              i_fill_we, d_fill_we, i_tag_we, d_tag_we, busy, i_stall, d_stall};
   endfunction

   // Queue the eight reads and eight fill writes a block fill must produce.
   task automatic expect_fill(input bit is_d, input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] blk, a;
      blk = addr & 16'hFFF0;
      for (int k = 0; k < WORDS; k++) begin
         a = blk + ADDR_W'(2 * k);
         mem_q.push_back('{wr: 1'b0, addr: a, data: '0});
         fill_q.push_back('{i_fill: !is_d, d_fill: is_d,
                            i_tag: !is_d && (k == WORDS-1), d_tag: is_d && (k == WORDS-1),
                            idx: IDX_W'(k), data: mem_model(a)});
      end
   endtask

   // Scoreboard monitor: every memory request and fill write must match the queue head.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_en) begin
            if (mem_q.size() == 0) begin
               flag_fail("mem request");
            end else begin
               check_output("mem request", {31'b0, mem_wr, mem_addr, mem_wdata & {DATA_W{mem_wr}}},
                            {31'b0, mem_q.pop_front()});
            end
         end
         if (i_fill_we | d_fill_we | i_tag_we | d_tag_we) begin
            if (fill_q.size() == 0) begin
               flag_fail("fill write");
            end else begin
               check_output("fill write",
                            {37'b0, i_fill_we, d_fill_we, i_tag_we, d_tag_we, fill_idx, fill_data},
                            {37'b0, fill_q.pop_front()});
            end
         end
      end
   end

   task automatic apply_stimulus(input logic im, input logic [ADDR_W-1:0] ia,
                                 input logic dm, input logic [ADDR_W-1:0] da,
                                 input logic wr, input logic [ADDR_W-1:0] wa,
                                 input logic [DATA_W-1:0] wd);
      @(posedge clk);
      #1;
      i_miss = im; i_miss_addr = ia;
      d_miss = dm; d_miss_addr = da;
      d_wr_req = wr; d_wr_addr = wa; d_wr_data = wd;
   endtask

   // Counts negedges from the current cycle (n=0) until the selected tag_we.
   task automatic wait_tag(input bit is_d, output int n, output bit ds_all, output bit is_all);
      ds_all = 1'b1;
      is_all = 1'b1;
      for (n = 0; n < 60; n++) begin
         @(negedge clk);
         if (!d_stall) ds_all = 1'b0;
         if (!i_stall) is_all = 1'b0;
         if (is_d ? d_tag_we : i_tag_we) return;
      end
      n = -1;
      flag_fail("tag_we timeout");
   endtask

   typedef struct packed {
      logic i_miss, d_miss, d_wr_req;
      logic exp_i_stall, exp_d_stall, exp_mem_en, exp_mem_wr;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int  n;
      bit  ds_all, is_all, we_seen, busy_seen, found;

      rst_n = 1'b0;
      i_miss = 0; d_miss = 0; d_wr_req = 0;
      i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;

      vecs[0] = '{0,0,0, 0,0,0,0};
      vecs[1] = '{1,0,0, 1,0,0,0};
      vecs[2] = '{0,1,0, 0,1,0,0};
      vecs[3] = '{0,0,1, 0,0,1,1};
      vecs[4] = '{0,1,1, 0,1,0,0};
      vecs[5] = '{1,0,1, 1,0,1,1};
      vecs[6] = '{1,1,1, 1,1,0,0};
      vecs[7] = '{1,1,0, 1,1,0,0};

      repeat (3) @(posedge clk);
      #2;
      check_output("reset outputs", all_outs(), 64'd0);
      rst_n = 1'b1;

      // Idle-state stall and priority vectors, applied and removed between edges.
      for (int v = 0; v < 8; v++) begin
         @(posedge clk);
         #1;
         i_miss = vecs[v].i_miss; d_miss = vecs[v].d_miss; d_wr_req = vecs[v].d_wr_req;
         #3;
         check_output($sformatf("idle vector %0d", v), {59'b0, i_stall, d_stall, mem_en, mem_wr, busy},
                      {59'b0, vecs[v].exp_i_stall, vecs[v].exp_d_stall,
                       vecs[v].exp_mem_en, vecs[v].exp_mem_wr, 1'b0});
         i_miss = 0; d_miss = 0; d_wr_req = 0;
      end

      // D miss fill: tag at grant+WORDS+LAT, stall held throughout.
      expect_fill(1'b1, 16'h1234);
      apply_stimulus(0, 0, 1, 16'h1234, 0, 0, 0);
      wait_tag(1'b1, n, ds_all, is_all);
      check_output("t1 tag latency", 64'(n), 64'd12);
      check_output("t1 d_stall held", {63'b0, ds_all}, 64'd1);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check_output("t1 back to idle", {63'b0, busy}, 64'd0);

      // Simultaneous misses: D first, one idle cycle, then I.
      expect_fill(1'b1, 16'h2002);
      expect_fill(1'b0, 16'h0040);
      apply_stimulus(1, 16'h0040, 1, 16'h2002, 0, 0, 0);
      wait_tag(1'b1, n, ds_all, is_all);
      check_output("t2 d tag latency", 64'(n), 64'd12);
      apply_stimulus(1, 16'h0040, 0, 0, 0, 0, 0);
      @(negedge clk);
      check_output("t2 idle gap", {63'b0, busy}, 64'd0);
      @(negedge clk);
      check_output("t2 i granted", {63'b0, busy}, 64'd1);
      wait_tag(1'b0, n, ds_all, is_all);
      check_output("t2 i tag latency", 64'(n), 64'd10);
      check_output("t2 i_stall held", {63'b0, is_all}, 64'd1);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);

      // Store while idle: one write cycle, no stall.
      mem_q.push_back('{wr: 1'b1, addr: 16'h0100, data: 16'hBEEF});
      apply_stimulus(0, 0, 0, 0, 1, 16'h0100, 16'hBEEF);
      @(negedge clk);
      check_output("t3 stall/busy", {62'b0, d_stall, busy}, 64'd0);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);

      // Store behind an I fill, issued before a following I miss.
      expect_fill(1'b0, 16'h0300);
      apply_stimulus(1, 16'h0300, 0, 0, 0, 0, 0);
      repeat (2) apply_stimulus(1, 16'h0300, 0, 0, 0, 0, 0);
      mem_q.push_back('{wr: 1'b1, addr: 16'h0500, data: 16'h1111});
      apply_stimulus(1, 16'h0300, 0, 0, 1, 16'h0500, 16'h1111);
      wait_tag(1'b0, n, ds_all, is_all);
      check_output("t4 tag latency", 64'(n), 64'd9);
      check_output("t4 d_stall while busy", {63'b0, ds_all}, 64'd1);
      expect_fill(1'b0, 16'h0600);
      apply_stimulus(1, 16'h0600, 0, 0, 1, 16'h0500, 16'h1111);
      @(negedge clk);
      check_output("t4 store slot", {60'b0, busy, d_stall, mem_en, mem_wr}, 64'b0011);
      apply_stimulus(1, 16'h0600, 0, 0, 0, 0, 0);
      wait_tag(1'b0, n, ds_all, is_all);
      check_output("t4 second i tag latency", 64'(n), 64'd12);
      apply_stimulus(0, 0, 0, 0, 0, 0, 0);

      // Reset mid-fill once three words have returned.
      expect_fill(1'b1, 16'h4000);
      apply_stimulus(0, 0, 1, 16'h4000, 0, 0, 0);
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (d_fill_we && fill_idx == 3'd2) found = 1'b1;
      end
      check_output("t5 third return seen", {63'b0, found}, 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      d_miss = 1'b0;
      mem_q.delete();
      fill_q.delete();
      #1;
      check_output("t5 async reset outputs", all_outs(), 64'd0);
      we_seen = 1'b0;
      busy_seen = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (i_fill_we | d_fill_we | i_tag_we | d_tag_we) we_seen = 1'b1;
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (i_fill_we | d_fill_we | i_tag_we | d_tag_we) we_seen = 1'b1;
         if (busy) busy_seen = 1'b1;
      end
      check_output("t5 stale returns ignored", {62'b0, we_seen, busy_seen}, 64'd0);

      // Spurious rvalid with nothing outstanding.
      @(posedge clk);
      #1;
      inject = 1'b1;
      @(negedge clk);
      check_output("t6 spurious rvalid", {58'b0, i_fill_we, d_fill_we, i_tag_we, d_tag_we, busy, mem_en},
                   64'd0);
      @(posedge clk);
      #1;
      inject = 1'b0;
      @(negedge clk);
      check_output("t6 stays idle", {63'b0, busy}, 64'd0);

      check_output("scoreboard drained", {32'(mem_q.size()), 32'(fill_q.size())}, 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
